sniff_fifo_ctrl: RTL



---
 rtl/sniff_fifo_ctrl_pkg.sv | 28 ++
 rtl/sniff_fifo_mem.sv | 23 ++
 rtl/sniff_fifo_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sniff_fifo_ctrl_pkg.sv
// Shared definitions for the sniff capture FIFO controller: register map,
// status byte layout and flush FSM encoding.
package sniff_fifo_ctrl_pkg;

  localparam logic [5:0] REG_FIFO_RD      = 6'd10;
  localparam logic [5:0] REG_FIFO_STAT    = 6'd11;
  localparam logic [5:0] REG_EMPTY_THRESH = 6'd12;
  localparam logic [5:0] REG_FULL_THRESH  = 6'd13;

  localparam int ST_EMPTY        = 0;
  localparam int ST_UNDERFLOW    = 1;
  localparam int ST_EMPTY_THRESH = 2;
  localparam int ST_FULL         = 3;
  localparam int ST_OVERFLOW     = 4;
  localparam int ST_FULL_THRESH  = 5;
  localparam int ST_FLUSHING     = 6;

  typedef enum logic [0:0] {
    FSM_IDLE  = 1'b0,
    FSM_FLUSH = 1'b1
  } fsm_state_e;

  // Data bytes needed for one entry plus the trailing status byte.
  function automatic int bytes_per_word(int data_width);
    return (data_width + 7) / 8 + 1;
  endfunction

endpackage

// File: rtl/sniff_fifo_mem.sv
// Simple dual-port capture storage: registered write, asynchronous read so the
// head entry falls through to the register bus without an extra cycle.
module sniff_fifo_mem #(
  parameter int pWIDTH  = 18,
  parameter int pADDR_W = 11
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [pADDR_W-1:0] wr_addr,
  input  logic [pWIDTH-1:0]  wr_data,
  input  logic [pADDR_W-1:0] rd_addr,
  output logic [pWIDTH-1:0]  rd_data
);

  logic [pWIDTH-1:0] mem [2**pADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sniff_fifo_ctrl.sv
// Capture FIFO controller: bytewise register readout of a FWFT FIFO, status and
// threshold registers, and an arm-triggered flush that drains stale entries.
module sniff_fifo_ctrl
  import sniff_fifo_ctrl_pkg::*;
#(
  parameter int         pDATA_WIDTH           = 18,
  parameter int         pDEPTH_LOG2           = 11,
  parameter logic [5:0] pREG_FIFO_RD          = REG_FIFO_RD,
  parameter logic [5:0] pREG_FIFO_STAT        = REG_FIFO_STAT,
  parameter logic [5:0] pREG_EMPTY_THRESH     = REG_EMPTY_THRESH,
  parameter logic [5:0] pREG_FULL_THRESH      = REG_FULL_THRESH,
  parameter int         pEMPTY_THRESH_DEFAULT = 16,
  parameter int         pFULL_THRESH_DEFAULT  = 2**pDEPTH_LOG2 - 16
) (
  input  logic                   cwusb_clk,
  input  logic                   reset_i,
  input  logic [5:0]             reg_address,
  input  logic [15:0]            reg_bytecnt,
  input  logic [7:0]             write_data,
  input  logic                   reg_read,
  input  logic                   reg_write,
  input  logic                   reg_addrvalid,
  output logic [7:0]             read_data,
  input  logic                   I_wr_en,
  input  logic [pDATA_WIDTH-1:0] I_din,
  input  logic                   I_arm,
  output logic                   O_arm,
  output logic                   O_full,
  output logic [7:0]             O_status,
  output fsm_state_e             fsm_state,
  output logic [pDEPTH_LOG2:0]   fifo_count
);

  localparam int NB    = bytes_per_word(pDATA_WIDTH);
  localparam int CW    = pDEPTH_LOG2 + 1;
  localparam int TB    = (CW + 7) / 8;
  localparam int PADW  = 8 * (NB - 1);
  localparam logic [15:0]   NB16    = 16'(NB);
  localparam logic [CW-1:0] DEPTH_C = CW'(2**pDEPTH_LOG2);

  logic [pDEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic [CW-1:0]          empty_thr, full_thr;
  logic                   underflow, overflow_blocked;
  logic                   I_arm_r;
  fsm_state_e             state;
  logic [7:0]             rdata_r;

  logic [pDATA_WIDTH-1:0] head;
  logic [PADW-1:0]        head_pad;
  logic [15:0]            byte_idx;
  logic [7:0]             fifo_byte;
  logic [7:0]             status;
  logic empty, full, addr_fifo, arm_rise;
  logic reg_pop_req, flush_pop, pop, push, underflow_evt, overflow_evt;

  function automatic logic [CW-1:0] put_byte(logic [CW-1:0] cur, logic [15:0] idx,
                                             logic [7:0] d);
    logic [8*TB-1:0] tmp;
    tmp         = '0;
    tmp[CW-1:0] = cur;
    for (int b = 0; b < TB; b++) begin
      if (idx == 16'(b)) tmp[8*b +: 8] = d;
    end
    return tmp[CW-1:0];
  endfunction

  function automatic logic [7:0] get_byte(logic [CW-1:0] cur, logic [15:0] idx);
    logic [8*TB-1:0] tmp;
    logic [7:0]      r;
    tmp         = '0;
    tmp[CW-1:0] = cur;
    r           = 8'h00;
    for (int b = 0; b < TB; b++) begin
      if (idx == 16'(b)) r = tmp[8*b +: 8];
    end
    return r;
  endfunction

  sniff_fifo_mem #(
    .pWIDTH  (pDATA_WIDTH),
    .pADDR_W (pDEPTH_LOG2)
  ) u_mem (
    .clk     (cwusb_clk),
    .wr_en   (push & ~reset_i),
    .wr_addr (wr_ptr),
    .wr_data (I_din),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign addr_fifo = (reg_address == pREG_FIFO_RD);
  assign byte_idx  = reg_bytecnt % NB16;
  assign arm_rise  = I_arm & ~I_arm_r;

  // A register pop is the read of the last (status) byte of a word.
  assign reg_pop_req   = reg_addrvalid & reg_read & addr_fifo & (byte_idx == NB16 - 16'd1)
                         & (state == FSM_IDLE);
  assign flush_pop     = (state == FSM_FLUSH) & ~empty;
  assign pop           = (reg_pop_req & ~empty) | flush_pop;
  assign underflow_evt = reg_pop_req & empty;
  assign push          = I_wr_en & (~full | pop);
  assign overflow_evt  = I_wr_en & full & ~pop;

  always_comb begin
    status                  = 8'h00;
    status[ST_EMPTY]        = empty;
    status[ST_UNDERFLOW]    = underflow;
    status[ST_EMPTY_THRESH] = (count <= empty_thr) & ~empty;
    status[ST_FULL]         = full;
    status[ST_OVERFLOW]     = overflow_blocked;
    status[ST_FULL_THRESH]  = (count >= full_thr) & ~full;
    status[ST_FLUSHING]     = (state == FSM_FLUSH);
  end

  always_comb begin
    head_pad                  = '0;
    head_pad[pDATA_WIDTH-1:0] = head;
    fifo_byte                 = status;
    for (int k = 0; k < NB - 1; k++) begin
      if (byte_idx == 16'(k)) fifo_byte = head_pad[8*k +: 8];
    end
  end

  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      underflow        <= 1'b0;
      overflow_blocked <= 1'b0;
      I_arm_r          <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      I_arm_r <= I_arm;
      // A fresh event outranks the clear from the same arm edge.
      if (underflow_evt)     underflow <= 1'b1;
      else if (arm_rise)     underflow <= 1'b0;
      if (overflow_evt)      overflow_blocked <= 1'b1;
      else if (arm_rise)     overflow_blocked <= 1'b0;
    end
  end

  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i) begin
      state <= FSM_IDLE;
    end else begin
      case (state)
        FSM_IDLE:  if (arm_rise & ~empty) state <= FSM_FLUSH;
        FSM_FLUSH: if (empty) state <= FSM_IDLE;
        default:   state <= FSM_IDLE;
      endcase
    end
  end

  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i) begin
      empty_thr <= CW'(pEMPTY_THRESH_DEFAULT);
      full_thr  <= CW'(pFULL_THRESH_DEFAULT);
    end else if (reg_write & reg_addrvalid) begin
      if (reg_address == pREG_EMPTY_THRESH)
        empty_thr <= put_byte(empty_thr, reg_bytecnt, write_data);
      if (reg_address == pREG_FULL_THRESH)
        full_thr <= put_byte(full_thr, reg_bytecnt, write_data);
    end
  end

  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i) begin
      rdata_r <= 8'h00;
    end else if (reg_read & reg_addrvalid) begin
      if (reg_address == pREG_FIFO_STAT)         rdata_r <= status;
      else if (reg_address == pREG_EMPTY_THRESH) rdata_r <= get_byte(empty_thr, reg_bytecnt);
      else if (reg_address == pREG_FULL_THRESH)  rdata_r <= get_byte(full_thr, reg_bytecnt);
      else                                       rdata_r <= 8'h00;
    end else begin
      rdata_r <= 8'h00;
    end
  end

  assign read_data  = addr_fifo ? fifo_byte : rdata_r;
  assign O_arm      = I_arm_r & (state == FSM_IDLE);
  assign O_full     = full;
  assign O_status   = status;
  assign fsm_state  = state;
  assign fifo_count = count;

endmodule
